// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared constants and state type for the sequential add/sub unit
//
// Purpose : slice width, operation encodings and FSM state type used by
//           seq_addsub16.
// Ports   : none (package).

package addsub_pkg;

  localparam int SLICE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit carry-lookahead adder slice
//
// Purpose : s = x + y + cin, with all carries formed directly from the
//           per-bit generate/propagate terms (no ripple inside the slice).
// Ports   : x[3:0], y[3:0] - addends
//           cin            - carry in
//           s[3:0]         - sum
//           cout           - carry out of bit 3

module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  assign g = x & y;
  assign p = x ^ y;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ {c3, c2, c1, cin};
  assign cout = c4;

endmodule

// File: rtl/seq_addsub16.sv
// rtl/seq_addsub16.sv - multi-cycle add/subtract through one 4-bit CLA slice
//
// Purpose : computes a+b or a-b one nibble per clock, LSB first, reusing a
//           single cla4_slice. Subtraction is a + ~b + 1: B is inverted on
//           capture and the carry register is seeded with op.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           start        - request, sampled only when busy=0
//           op           - 0 = add, 1 = subtract
//           a, b         - operands, captured on the accepted start edge
//           busy         - high during the N nibble cycles
//           done         - one-cycle pulse, result and flags valid
//           result       - sum/difference, held until next accepted start
//           carry_out    - final carry (subtract: 1 = no borrow)
//           overflow     - two's-complement overflow
//           zero         - result == 0

module seq_addsub16
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;

  logic [SLICE_W-1:0] a_nib;
  logic [SLICE_W-1:0] b_nib;
  logic [SLICE_W-1:0] sum_nib;
  logic               slice_cout;
  logic [WIDTH-1:0]   next_result;
  logic               accept;

  assign a_nib = a_q[cnt*SLICE_W +: SLICE_W];
  assign b_nib = b_q[cnt*SLICE_W +: SLICE_W];

  cla4_slice u_slice (
    .x    (a_nib),
    .y    (b_nib),
    .cin  (carry_q),
    .s    (sum_nib),
    .cout (slice_cout)
  );

  // Result with the current nibble merged in; on the last nibble this is the
  // complete value, so the flags can be registered on the same edge.
  always_comb begin
    next_result = result;
    next_result[cnt*SLICE_W +: SLICE_W] = sum_nib;
  end

  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      a_q       <= a;
      b_q       <= b ^ {WIDTH{op}};
      carry_q   <= op;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      state     <= RUN;
    end else if (state == RUN) begin
      result  <= next_result;
      carry_q <= slice_cout;
      cnt     <= cnt + 1'b1;
      if (cnt == LAST) begin
        state     <= DONE;
        carry_out <= slice_cout;
        // Overflow: operand signs agree (after inversion) but the sign of
        // the result differs from them.
        overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (next_result[WIDTH-1] != a_q[WIDTH-1]);
        zero      <= (next_result == '0);
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end

endmodule
